// File: rtl/factorial_engine.sv
// Iterative n! unit with start/done handshake, sticky overflow detection and
// optional saturation; one multiply per CALC cycle.
`timescale 1ns/1ps
module factorial_engine #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_cnt;
  logic             r_ovf_int;

  logic [PW-1:0]    w_prod;
  logic             w_prod_ovf;
  logic             w_cnt_le1;
  logic             w_accept;
  logic             w_step;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_load_result;
  logic [WIDTH-1:0] w_result_nxt;

  assign w_prod     = PW'(r_acc) * PW'(r_cnt);
  assign w_prod_ovf = |w_prod[PW-1:WIDTH];
  assign w_cnt_le1  = (r_cnt <= WIDTH'(1));
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_step     = (r_state == S_CALC) && !w_cnt_le1;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CALC;
      S_CALC:  if (w_cnt_le1) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output next-values; flags are aligned with the state they describe so
  // busy/done/result/overflow all change on the same edge as the state.
  always_comb begin
    w_busy_nxt    = (w_state_nxt != S_IDLE);
    w_done_nxt    = (w_state_nxt == S_DONE);
    w_load_result = (r_state == S_CALC) && w_cnt_le1;
    w_result_nxt  = (SATURATE && r_ovf_int) ? '1 : r_acc;
  end

  // Accumulator, down-counter and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc     <= WIDTH'(1);
      r_cnt     <= '0;
      r_ovf_int <= 1'b0;
    end else if (w_accept) begin
      r_acc     <= WIDTH'(1);
      r_cnt     <= n;
      r_ovf_int <= 1'b0;
    end else if (w_step) begin
      r_acc     <= w_prod[WIDTH-1:0];
      r_cnt     <= r_cnt - WIDTH'(1);
      r_ovf_int <= r_ovf_int | w_prod_ovf;
    end
  end

  // Registered outputs; result/overflow hold until the next completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      busy <= w_busy_nxt;
      done <= w_done_nxt;
      if (w_load_result) begin
        result   <= w_result_nxt;
        overflow <= r_ovf_int;
      end
    end
  end

endmodule

// File: doc/factorial_engine.md
Name: factorial_engine

Overview:
- Parametrised iterative factorial unit; successor to the fixed 32-bit factorial datapath.
- Computes n! with a start/done handshake and an internal FSM in place of externally driven mux selects.
- Provides overflow detection and an optional saturation mode.
- Sits on the compute bus; a controller issues start and later samples result once done pulses.

Parameters:
- WIDTH, 32, width of n, accumulator, counter and result.
- SATURATE, 0, overflow mode. 0: result is n! mod 2^WIDTH. 1: result forced to all ones on overflow.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- n  input  WIDTH  operand; captured on an accepted start.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  factorial value; held until the next accepted start.
- overflow  output  1  high if the true n! exceeded 2^WIDTH-1; held with result.

Behaviour:
- Reset, asynchronous:
  - state goes to IDLE.
  - busy=0, done=0, result=0, overflow=0.
  - Internal accumulator acc=1, counter cnt=0.
- Reset mid-operation aborts the computation immediately; no done pulse is produced.
- State IDLE:
  - busy=0.
  - When start=1 at edge T: acc<=1, cnt<=n, ovf_int<=0, next state CALC.
  - result and overflow keep their previous values.
- State CALC:
  - If cnt<=1: next state DONE.
  - Otherwise: compute the full 2*WIDTH product p=acc*cnt; acc<=p[WIDTH-1:0]; cnt<=cnt-1.
  - If p[2*WIDTH-1:WIDTH]!=0, ovf_int<=1. This flag is sticky for the operation.
  - One multiply per cycle, using the combinational product.
- State DONE, one cycle:
  - done=1.
  - result<=(SATURATE && ovf_int) ? all ones : acc.
  - overflow<=ovf_int.
  - Next state IDLE.
  - result and overflow are registered so they are valid in the same cycle done=1.
- Latency from the start-accept edge T:
  - done high in cycle T+n+1 for n>=1.
  - done high in cycle T+2 for n=0.
  - 0! = 1! = 1.
- start handling:
  - start while busy=1 is ignored: no restart, no queuing.
  - start held high continuously re-triggers in each IDLE cycle.
  - Back-to-back throughput is one operation per n+2 cycles.
- n is sampled only at accept; later changes to n have no effect.
- Arithmetic:
  - Unsigned throughout.
  - Truncation is modular, so the non-saturating result equals n! mod 2^WIDTH.
  - Once ovf_int is set, computation continues to completion with no early exit, so latency is data-independent of overflow.
- done is never asserted in IDLE or CALC.
- busy deasserts in the cycle after done.

Test Plan:
- WIDTH=32, n=5, start one cycle -> busy high, done pulse 6 cycles after accept, result=120, overflow=0.
- n=0, then n=1 -> done 2 cycles after accept in both cases, result=1, overflow=0.
- WIDTH=32: n=12 -> result=479001600, overflow=0. n=13 with SATURATE=0 -> result=1932053504, overflow=1. n=13 with SATURATE=1 -> result=32'hFFFFFFFF, overflow=1.
- WIDTH=8: n=5 -> result=120, overflow=0. n=6 with SATURATE=0 -> result=208, overflow=1.
- n=5 accepted; start pulsed with n=3 two cycles later -> ignored; result=120, done exactly once, then new start accepted in IDLE.
- n=10 accepted; reset asserted mid-CALC (asynchronously, between edges) -> outputs clear immediately, no done; after release, n=4 -> result=24 in 5 cycles.
